// File: rtl/hdmi_pll_pkg.sv
// Shared types and constants for the HDMI PLL reconfiguration controller:
// FSM state encoding, dynamic-port opcodes and the per-mode divider table.
package hdmi_pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOLD_RST  = 3'd1,
    ST_PROG      = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_STABLE    = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } pll_state_t;

  // Dynamic reconfiguration port opcodes
  localparam logic [1:0] MDOPC_IDLE = 2'b00;
  localparam logic [1:0] MDOPC_WR   = 2'b01;
  localparam logic [1:0] MDOPC_CLR  = 2'b11;

  // Clear + three (write, increment) pairs
  localparam int PROG_STEPS = 7;

  // The table is always sized for the largest supported mode count
  localparam int MAX_MODES = 8;

  typedef struct packed {
    logic [7:0] idiv;
    logic [7:0] mdiv;
    logic [7:0] odiv0;
  } mode_triple_t;

  // Entry 0 sits in the least-significant slot.
  // With a 27 MHz reference: 0 -> 371.25 MHz, 1 -> 742.5 MHz, 2 -> 135 MHz.
  localparam mode_triple_t [MAX_MODES-1:0] DEFAULT_MODE_TABLE = {
    {5{24'h000000}},
    {8'd1, 8'd40, 8'd8},
    {8'd1, 8'd55, 8'd2},
    {8'd1, 8'd55, 8'd4}
  };

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clk domain.
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both clear to 0 so lock is never assumed at reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hdmi_pll_reconfig.sv
// HDMI video PLL reconfiguration controller. Holds the PLL in reset, writes
// the divider triple for the selected mode through the dynamic port, waits for
// a stable lock and only then releases the pixel/serialiser domain. Lock loss
// and lock timeouts trigger bounded retries; exhausting them parks in FAIL.
//
// Mode request handshake: a request is taken on a clk edge where
// mode_req_valid && mode_req_ready are both high and mode_req < NUM_MODES.
// mode_req_ready is high only in RUN and FAIL; valid while not ready is
// dropped (nothing is queued), and out-of-range indices are dropped too.
module hdmi_pll_reconfig
  import hdmi_pll_pkg::*;
#(
  parameter int                            NUM_MODES     = 3,
  parameter mode_triple_t [MAX_MODES-1:0]  MODE_TABLE    = DEFAULT_MODE_TABLE,
  parameter int                            RST_CYCLES    = 16,
  parameter int                            LOCK_TIMEOUT  = 270000,
  parameter int                            STABLE_CYCLES = 1024,
  parameter int                            MAX_RETRY     = 3,
  localparam int                           MODE_W        = $clog2(NUM_MODES)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              mode_req_valid,
  output logic              mode_req_ready,
  output logic              pll_reset,
  output logic [1:0]        pll_mdopc,
  output logic              pll_mdainc,
  output logic [7:0]        pll_mdwdi,
  input  logic              pll_lock,
  output logic              pix_rst_n,
  output logic [MODE_W-1:0] cur_mode,
  output logic              busy,
  output logic              err,
  output logic [2:0]        state_dbg
);

  // One timer serves the reset hold, the PROG step index, the lock timeout
  // and the stable-lock count; it must cover the longest of them.
  localparam int TMR_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  localparam logic [TMR_W-1:0]  RST_LAST     = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]  PROG_LAST    = TMR_W'(PROG_STEPS - 1);
  localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0]  RETRY_MAX    = RTY_W'(MAX_RETRY);
  localparam logic [MODE_W:0]   MODE_LIMIT   = (MODE_W + 1)'(NUM_MODES);

  pll_state_t        state, state_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [RTY_W-1:0]  retry, retry_nxt;
  logic [MODE_W-1:0] target, target_nxt;
  logic [MODE_W-1:0] cur_mode_nxt;
  logic              err_nxt;
  logic              lock_s;
  logic              in_service;
  logic              req_take;
  logic              attempt_fail;
  logic [2:0]        prog_step;
  logic [2:0]        tbl_idx;
  mode_triple_t      entry;

  lock_sync u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign in_service = (state == ST_RUN) || (state == ST_FAIL);
  assign req_take   = mode_req_valid && in_service && ({1'b0, mode_req} < MODE_LIMIT);
  assign prog_step  = timer[2:0];
  assign tbl_idx    = 3'(target);
  assign entry      = MODE_TABLE[tbl_idx];
  assign state_dbg  = state;

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      timer    <= '0;
      retry    <= '0;
      target   <= '0;
      cur_mode <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      retry    <= retry_nxt;
      target   <= target_nxt;
      cur_mode <= cur_mode_nxt;
      err      <= err_nxt;
    end
  end

  // Next-state logic and Moore output decode
  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    retry_nxt      = retry;
    target_nxt     = target;
    cur_mode_nxt   = cur_mode;
    err_nxt        = err;
    attempt_fail   = 1'b0;

    pll_reset      = 1'b0;
    pix_rst_n      = 1'b0;
    busy           = !in_service;
    mode_req_ready = in_service;
    pll_mdopc      = MDOPC_IDLE;
    pll_mdainc     = 1'b0;
    pll_mdwdi      = 8'h00;

    unique case (state)
      ST_IDLE: begin
        pll_reset  = 1'b1;
        target_nxt = '0;
        timer_nxt  = '0;
        state_nxt  = ST_HOLD_RST;
      end

      ST_HOLD_RST: begin
        pll_reset = 1'b1;
        if (timer == RST_LAST) begin
          timer_nxt = '0;
          state_nxt = ST_PROG;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      ST_PROG: begin
        pll_reset = 1'b1;
        unique case (prog_step)
          3'd0: pll_mdopc = MDOPC_CLR;
          3'd1: begin pll_mdopc = MDOPC_WR; pll_mdwdi = entry.idiv;  end
          3'd3: begin pll_mdopc = MDOPC_WR; pll_mdwdi = entry.mdiv;  end
          3'd5: begin pll_mdopc = MDOPC_WR; pll_mdwdi = entry.odiv0; end
          3'd2, 3'd4, 3'd6: pll_mdainc = 1'b1;
          default: ;
        endcase
        if (timer == PROG_LAST) begin
          timer_nxt    = '0;
          cur_mode_nxt = target;
          state_nxt    = ST_WAIT_LOCK;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s) begin
          timer_nxt = '0;
          state_nxt = ST_STABLE;
        end else if (timer >= TIMEOUT_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      ST_STABLE: begin
        if (!lock_s) begin
          // Timer is deliberately kept so a flapping lock still times out
          state_nxt = ST_WAIT_LOCK;
        end else if (timer == STABLE_LAST) begin
          timer_nxt = '0;
          retry_nxt = '0;
          state_nxt = ST_RUN;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      ST_RUN: begin
        pix_rst_n = 1'b1;
        retry_nxt = '0;
        // A request outranks a simultaneous lock loss
        if (!req_take && !lock_s) begin
          attempt_fail = 1'b1;
        end
      end

      ST_FAIL: ;

      default: begin
        pll_reset = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase

    if (attempt_fail) begin
      timer_nxt = '0;
      retry_nxt = retry + 1'b1;
      if (retry >= RETRY_MAX) begin
        err_nxt   = 1'b1;
        state_nxt = ST_FAIL;
      end else begin
        state_nxt = ST_HOLD_RST;
      end
    end

    if (req_take) begin
      target_nxt = mode_req;
      retry_nxt  = '0;
      err_nxt    = 1'b0;
      timer_nxt  = '0;
      state_nxt  = ST_HOLD_RST;
    end
  end

endmodule

// File: tb/tb_hdmi_pll_reconfig.sv
// Bench for hdmi_pll_reconfig: directed scenarios with a behavioural PLL lock
// model, a write scoreboard fed from hand-entered divider values, and direct
// status checks.
module tb_hdmi_pll_reconfig;
  import hdmi_pll_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] mode_req = 2'd0;
  logic       mode_req_valid = 1'b0;
  logic       mode_req_ready;
  logic       pll_reset;
  logic [1:0] pll_mdopc;
  logic       pll_mdainc;
  logic [7:0] pll_mdwdi;
  logic       pll_lock = 1'b0;
  logic       pix_rst_n;
  logic [1:0] cur_mode;
  logic       busy;
  logic       err;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  int clr_cnt = 0;
  int ainc_cnt = 0;
  int rst_rise = 0;
  logic prev_pll_reset = 1'b1;

  int  lock_delay = 100;
  bit  lock_en = 1'b1;
  bit  force_low = 1'b0;
  int  lk_cnt = 0;

  hdmi_pll_reconfig #(
    .LOCK_TIMEOUT (1000)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .mode_req_ready (mode_req_ready),
    .pll_reset      (pll_reset),
    .pll_mdopc      (pll_mdopc),
    .pll_mdainc     (pll_mdainc),
    .pll_mdwdi      (pll_mdwdi),
    .pll_lock       (pll_lock),
    .pix_rst_n      (pix_rst_n),
    .cur_mode       (cur_mode),
    .busy           (busy),
    .err            (err),
    .state_dbg      (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // PLL model: lock is lost under reset and returns lock_delay cycles after it
  always begin
    @(posedge clk);
    #1;
    if (pll_reset) begin
      lk_cnt   = 0;
      pll_lock = 1'b0;
    end else if (!lock_en || force_low) begin
      pll_lock = 1'b0;
    end else if (lk_cnt >= lock_delay) begin
      pll_lock = 1'b1;
    end else begin
      lk_cnt++;
    end
  end

  // Monitor: every dynamic-port write is checked against the expected queue
  always @(negedge clk) begin
    if (resetn) begin
      if (pll_mdopc == MDOPC_WR) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: got %0d with nothing expected", pll_mdwdi);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (pll_mdwdi !== e) begin
            n_fail++;
            $display("FAIL wr_data: got %0d expected %0d", pll_mdwdi, e);
          end
        end
      end
      if (pll_mdopc == MDOPC_CLR) clr_cnt++;
      if (pll_mdainc) ainc_cnt++;
    end
    if (pll_reset && !prev_pll_reset) rst_rise++;
    prev_pll_reset = pll_reset;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wait_state(input pll_state_t st, input int budget, input string nm, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (state_dbg != 3'(st) && cyc < budget);
    if (state_dbg != 3'(st)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout, state %0d expected %0d", nm, state_dbg, 3'(st));
    end
  endtask

  // Hand-entered divider triples: {IDIV, MDIV, ODIV0}
  task automatic push_mode(input int m);
    case (m)
      0: begin exp_q.push_back(8'd1); exp_q.push_back(8'd55); exp_q.push_back(8'd4); end
      1: begin exp_q.push_back(8'd1); exp_q.push_back(8'd55); exp_q.push_back(8'd2); end
      default: begin exp_q.push_back(8'd1); exp_q.push_back(8'd40); exp_q.push_back(8'd8); end
    endcase
  endtask

  task automatic send_req(input logic [1:0] m);
    @(posedge clk);
    #1;
    mode_req       = m;
    mode_req_valid = 1'b1;
    @(posedge clk);
    #1;
    mode_req_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    int base_clr;
    int base_ainc;
    int base_rst;

    // Reset values
    #12;
    check("rst_pll_reset", pll_reset, 1);
    check("rst_pix_rst_n", pix_rst_n, 0);
    check("rst_mdopc", pll_mdopc, 0);
    check("rst_mdainc", pll_mdainc, 0);
    check("rst_mdwdi", pll_mdwdi, 0);
    check("rst_busy", busy, 1);
    check("rst_ready", mode_req_ready, 0);
    check("rst_err", err, 0);
    check("rst_cur_mode", cur_mode, 0);

    // Startup into mode 0
    push_mode(0);
    base_ainc = ainc_cnt;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_state(ST_HOLD_RST, 5, "enter_hold", cyc);
    check("hold_pll_reset", pll_reset, 1);
    check("hold_pix_rst_n", pix_rst_n, 0);
    wait_state(ST_PROG, 40, "enter_prog", cyc);
    check("hold_len", cyc, 16);
    check("prog_clr", pll_mdopc, 3);
    check("prog_pll_reset", pll_reset, 1);
    wait_state(ST_WAIT_LOCK, 20, "enter_wait", cyc);
    check("prog_len", cyc, 7);
    check("wait_pll_reset", pll_reset, 0);
    check("prog_ainc", ainc_cnt - base_ainc, 3);
    wait_state(ST_RUN, 2000, "startup_run", cyc);
    check_range("startup_latency", cyc, 1124, 1128);
    check("startup_pix", pix_rst_n, 1);
    check("startup_cur", cur_mode, 0);
    check("startup_ready", mode_req_ready, 1);

    // Out-of-range request is dropped
    base_rst = rst_rise;
    base_clr = clr_cnt;
    send_req(2'd3);
    repeat (20) @(negedge clk);
    check("bad_req_state", state_dbg, 3'(ST_RUN));
    check("bad_req_rst", rst_rise - base_rst, 0);
    check("bad_req_clr", clr_cnt - base_clr, 0);

    // Switch to mode 2; a request while busy is ignored
    push_mode(2);
    send_req(2'd2);
    @(negedge clk);
    check("m2_pix_low", pix_rst_n, 0);
    check("m2_state", state_dbg, 3'(ST_HOLD_RST));
    send_req(2'd1);
    wait_state(ST_RUN, 2000, "m2_run", cyc);
    check("m2_cur", cur_mode, 2);

    // Same-mode request forces a full reprogram
    push_mode(2);
    base_clr = clr_cnt;
    send_req(2'd2);
    wait_state(ST_RUN, 2000, "same_run", cyc);
    check("same_clr", clr_cnt - base_clr, 1);

    // Three-cycle lock glitch causes one relock
    push_mode(2);
    base_clr = clr_cnt;
    @(negedge clk);
    force_low = 1'b1;
    repeat (3) @(negedge clk);
    force_low = 1'b0;
    wait_state(ST_HOLD_RST, 20, "glitch_hold", cyc);
    check("glitch_pix", pix_rst_n, 0);
    wait_state(ST_RUN, 2000, "glitch_run", cyc);
    check("glitch_clr", clr_cnt - base_clr, 1);
    check("glitch_err", err, 0);
    check("glitch_cur", cur_mode, 2);

    // Lock never arrives: four attempts then FAIL
    lock_en = 1'b0;
    repeat (4) push_mode(1);
    base_clr = clr_cnt;
    send_req(2'd1);
    wait_state(ST_FAIL, 6000, "fail_enter", cyc);
    check("fail_attempts", clr_cnt - base_clr, 4);
    check("fail_err", err, 1);
    check("fail_ready", mode_req_ready, 1);
    check("fail_busy", busy, 0);
    check("fail_pix", pix_rst_n, 0);

    // Request from FAIL clears err and recovers
    lock_en = 1'b1;
    push_mode(0);
    send_req(2'd0);
    @(negedge clk);
    check("recover_err", err, 0);
    check("recover_busy", busy, 1);
    wait_state(ST_RUN, 2000, "recover_run", cyc);
    check("recover_cur", cur_mode, 0);

    // Request and lock loss in the same RUN cycle: the request wins
    push_mode(1);
    @(negedge clk);
    force_low = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mode_req       = 2'd1;
    mode_req_valid = 1'b1;
    @(posedge clk);
    #1;
    mode_req_valid = 1'b0;
    force_low      = 1'b0;
    @(negedge clk);
    check("race_state", state_dbg, 3'(ST_HOLD_RST));
    wait_state(ST_RUN, 2000, "race_run", cyc);
    check("race_cur", cur_mode, 1);

    // Reset during the MDIV write abandons the sequence
    push_mode(2);
    send_req(2'd2);
    wait_state(ST_PROG, 40, "mid_prog", cyc);
    repeat (3) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_state", state_dbg, 3'(ST_IDLE));
    check("midrst_pll_reset", pll_reset, 1);
    check("midrst_mdopc", pll_mdopc, 0);
    check("midrst_mdwdi", pll_mdwdi, 0);
    check("midrst_cur", cur_mode, 0);
    check("midrst_busy", busy, 1);
    exp_q.delete();
    push_mode(0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_state(ST_RUN, 2000, "midrst_run", cyc);
    check("midrst_final_cur", cur_mode, 0);
    check("midrst_final_pix", pix_rst_n, 1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_pll_reconfig.md
HDMI_PLL_RECONFIG -- requirements
Module: hdmi_pll_reconfig

Interface
REQ-001 SHALL have parameter NUM_MODES, default 3: number of selectable video clock modes, 2..8.
REQ-002 SHALL have parameter MODE_TABLE, default {IDIV,MDIV,ODIV0} = {1,55,4},{1,55,2},{1,40,8}: one byte triple per mode.
- With a 27 MHz input these give 371.25, 742.5 and 135 MHz.
REQ-003 SHALL have parameter RST_CYCLES, default 16: PLL reset hold length in clk cycles.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 270000: maximum cycles to wait for lock (10 ms at 27 MHz).
REQ-005 SHALL have parameter STABLE_CYCLES, default 1024: cycles lock must stay continuously high before it is accepted.
REQ-006 SHALL have parameter MAX_RETRY, default 3: relock attempts before failure.
REQ-007 SHALL have port clk, input, 1 bit: free-running 27 MHz reference clock; also drives PLL MDCLK externally.
REQ-008 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port mode_req, input, MODE_W=$clog2(NUM_MODES) bits: requested mode index.
REQ-010 SHALL have port mode_req_valid, input, 1 bit: request strobe.
REQ-011 SHALL have port mode_req_ready, output, 1 bit: high only in RUN and FAIL.
REQ-012 SHALL have port pll_reset, output, 1 bit: drives PLL RESET.
REQ-013 SHALL have port pll_mdopc, output, 2 bits: dynamic-port opcode; 00 idle, 01 write, 11 address clear.
REQ-014 SHALL have port pll_mdainc, output, 1 bit: dynamic-port address increment pulse.
REQ-015 SHALL have port pll_mdwdi, output, 8 bits: dynamic-port write data.
REQ-016 SHALL have port pll_lock, input, 1 bit: PLL LOCK, asynchronous to clk.
REQ-017 SHALL have port pix_rst_n, output, 1 bit: active-low reset for the pixel/serialiser domain.
REQ-018 SHALL have port cur_mode, output, MODE_W bits: mode currently programmed.
REQ-019 SHALL have port busy, output, 1 bit: high in every state other than RUN and FAIL.
REQ-020 SHALL have port err, output, 1 bit: sticky retry-exhausted flag.

Function
REQ-021 SHALL implement the states IDLE, HOLD_RST, PROG, WAIT_LOCK, STABLE, RUN and FAIL.
REQ-022 SHALL leave IDLE after reset and enter HOLD_RST with target mode 0.
REQ-023 HOLD_RST SHALL assert pll_reset and hold pix_rst_n=0 for exactly RST_CYCLES cycles, then go to PROG.
REQ-024 PROG SHALL run for 7 cycles with pll_reset high throughout:
- cycle 1: mdopc=11.
- cycles 2,4,6: mdopc=01, mdwdi=IDIV, MDIV, ODIV0 in turn.
- cycles 3,5,7: mdainc=1.
- mdopc SHALL be 00 on all non-write cycles.
REQ-025 After PROG, pll_reset SHALL deassert, cur_mode SHALL update to the target, the lock timer SHALL clear, and the FSM SHALL enter WAIT_LOCK.
REQ-026 pll_lock SHALL pass through a 2-flop synchroniser; every lock reference below means the synchronised lock_s.
REQ-027 WAIT_LOCK: lock_s=1 SHALL go to STABLE; LOCK_TIMEOUT cycles without lock SHALL count as a failed attempt.
REQ-028 STABLE SHALL count consecutive lock_s=1 cycles; a 0 SHALL return to WAIT_LOCK without resetting the timeout timer; STABLE_CYCLES consecutive highs SHALL go to RUN.
REQ-029 RUN SHALL drive pix_rst_n=1 and clear the retry counter.
REQ-030 In RUN, lock_s=0 SHALL set pix_rst_n=0 on the next cycle and enter HOLD_RST with the same target.
- This counts as an attempt.
REQ-031 A failed attempt SHALL increment the retry counter and re-enter HOLD_RST; once the counter exceeds MAX_RETRY the FSM SHALL enter FAIL and set err.
REQ-032 mode_req_valid && mode_req_ready SHALL latch mode_req as the new target and enter HOLD_RST with retries cleared.
- A request accepted in FAIL SHALL also clear err.
REQ-033 A mode_req value >= NUM_MODES SHALL be ignored and leave the state unchanged.
REQ-034 A request equal to cur_mode while in RUN SHALL be accepted and SHALL force a full reprogram.
REQ-035 mode_req_valid while busy SHALL be ignored; requests are not queued.
REQ-036 If lock loss and a request occur in the same RUN cycle, the request SHALL win.
REQ-037 pix_rst_n SHALL be 0 in every state except RUN.
REQ-038 The timer SHALL be a single counter of $clog2(LOCK_TIMEOUT+1) bits, reused across states and cleared on each state entry except STABLE to WAIT_LOCK.

Reset
REQ-039 On resetn=0, asynchronously:
- state=IDLE, pll_reset=1, pix_rst_n=0, mdopc=00, mdainc=0, mdwdi=0;
- cur_mode=0, err=0, busy=1, mode_req_ready=0;
- counters and synchroniser flops = 0.
REQ-040 Reset asserted mid-PROG or mid-WAIT_LOCK SHALL abandon the sequence; after release, startup SHALL restart with mode 0.

Structure
REQ-041 Package hdmi_pll_pkg SHALL hold:
- the state enum;
- the mdopc constants (MDOPC_IDLE, MDOPC_WR, MDOPC_CLR);
- the mode-triple typedef and the default mode table.
REQ-042 The synchroniser SHALL be a sub-module lock_sync (2-flop, async active-low reset to 0); everything else SHALL be a single FSM.

Verification
REQ-043 Startup with pll_lock rising 100 cycles after the PROG writes -> mdwdi 1,55,4 written; RUN reached after 100+2+1024 cycles ±2; pix_rst_n=1; cur_mode=0.
REQ-044 mode_req=2 accepted in RUN -> pix_rst_n=0 next cycle; writes 1,40,8; cur_mode=2; RUN reached again.
REQ-045 pll_lock held 0 (use LOCK_TIMEOUT=1000) -> 4 attempts; err=1; FSM in FAIL; mode_req_ready=1; busy=0.
REQ-046 Lock glitch low for 3 cycles while in RUN -> one relock; err stays 0; RUN regained.
REQ-047 mode_req=3 with NUM_MODES=3 -> ignored; no pll_reset pulse.
REQ-048 resetn pulsed during the PROG MDIV write -> all outputs at reset values immediately; the sequence restarts with IDIV=1.
